pi_regulator: RTL

Sequential PI compensator that consumes signed error samples from the PI loop's error stage and produces a saturated control output. It uses one shared multiplier over a five-state FSM, keeps an anti-windup-clamped integrator, and presents the result over a valid/ready output handshake. It sits between the error stage and the actuator/PWM stage of the PI loop.

---
 rtl/pi_ctrl_pkg.sv | 18 +
 rtl/pi_regulator_if.sv | 27 ++
 rtl/sat_clamp.sv | 23 ++
 rtl/pi_regulator.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pi_ctrl_pkg.sv
// Shared PI-loop constants: FSM state encoding and default fixed-point widths
// used by the error stage, the regulator and the PWM stage.
package pi_ctrl_pkg;

    localparam int PI_DATA_WIDTH = 16;
    localparam int PI_GAIN_WIDTH = 16;
    localparam int PI_GAIN_FRAC  = 12;
    localparam int PI_ACC_WIDTH  = 32;

    typedef logic [2:0] pi_state_t;

    localparam pi_state_t ST_IDLE  = 3'd0;
    localparam pi_state_t ST_MUL_P = 3'd1;
    localparam pi_state_t ST_MUL_I = 3'd2;
    localparam pi_state_t ST_SUM   = 3'd3;
    localparam pi_state_t ST_OUT   = 3'd4;

endpackage

// File: rtl/pi_regulator_if.sv
// Error-sample input handshake, per-sample gains/limits and control-output handshake.
interface pi_regulator_if #(
    parameter int DATA_WIDTH = pi_ctrl_pkg::PI_DATA_WIDTH,
    parameter int GAIN_WIDTH = pi_ctrl_pkg::PI_GAIN_WIDTH
);
    logic                          error_valid;
    logic                          error_ready;
    logic signed [DATA_WIDTH-1:0]  error;
    logic signed [GAIN_WIDTH-1:0]  kp;
    logic signed [GAIN_WIDTH-1:0]  ki;
    logic signed [DATA_WIDTH-1:0]  out_min;
    logic signed [DATA_WIDTH-1:0]  out_max;
    logic                          integ_clear;
    logic                          u_valid;
    logic                          u_ready;
    logic signed [DATA_WIDTH-1:0]  u;

    modport master (
        output error_valid, error, kp, ki, out_min, out_max, integ_clear, u_ready,
        input  error_ready, u_valid, u
    );

    modport slave (
        input  error_valid, error, kp, ki, out_min, out_max, integ_clear, u_ready,
        output error_ready, u_valid, u
    );
endinterface

// File: rtl/sat_clamp.sv
// Combinational saturation of a wide signed value to [lim_min, lim_max]; the max
// limit is applied first, so inverted limits resolve to lim_min.
module sat_clamp #(
    parameter int WIDTH_IN  = 32,
    parameter int WIDTH_LIM = 16
) (
    input  logic signed [WIDTH_IN-1:0]  x,
    input  logic signed [WIDTH_LIM-1:0] lim_min,
    input  logic signed [WIDTH_LIM-1:0] lim_max,
    output logic signed [WIDTH_LIM-1:0] y
);
    logic signed [WIDTH_IN-1:0] min_ext;
    logic signed [WIDTH_IN-1:0] max_ext;
    logic signed [WIDTH_IN-1:0] hi;

    assign min_ext = WIDTH_IN'(lim_min);
    assign max_ext = WIDTH_IN'(lim_max);

    always_comb begin
        hi = (x > max_ext) ? max_ext : x;
        y  = (hi < min_ext) ? lim_min : hi[WIDTH_LIM-1:0];
    end
endmodule

// File: rtl/pi_regulator.sv
// Sequential PI compensator: one shared multiplier, anti-windup integrator, saturated output.
// Accept at T gives u_valid at T+4; u is held in OUT until u_ready, error_ready low meanwhile.
module pi_regulator
    import pi_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = PI_DATA_WIDTH,
    parameter int GAIN_WIDTH = PI_GAIN_WIDTH,
    parameter int GAIN_FRAC  = PI_GAIN_FRAC,
    parameter int ACC_WIDTH  = PI_ACC_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    pi_regulator_if.slave  bus
);
    localparam int PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH;
    localparam int WIDE_WIDTH = (PROD_WIDTH > ACC_WIDTH) ? PROD_WIDTH : ACC_WIDTH;

    pi_state_t state;
    pi_state_t state_next;
    logic      err_rdy;
    logic      u_vld;
    logic      accept;

    logic signed [DATA_WIDTH-1:0] e_q;
    logic signed [GAIN_WIDTH-1:0] kp_q;
    logic signed [GAIN_WIDTH-1:0] ki_q;
    logic signed [DATA_WIDTH-1:0] min_q;
    logic signed [DATA_WIDTH-1:0] max_q;
    logic signed [DATA_WIDTH-1:0] u_q;
    logic signed [ACC_WIDTH-1:0]  p_q;
    logic signed [ACC_WIDTH-1:0]  integ_next_q;
    logic signed [ACC_WIDTH-1:0]  integ;

    logic signed [GAIN_WIDTH-1:0] mul_gain;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [PROD_WIDTH-1:0] prod_sh;
    logic signed [WIDE_WIDTH-1:0] prod_wide;
    logic signed [ACC_WIDTH-1:0]  mul_res;
    logic signed [ACC_WIDTH-1:0]  integ_sum;
    logic signed [ACC_WIDTH-1:0]  out_sum;
    logic signed [DATA_WIDTH-1:0] integ_clamped;
    logic signed [DATA_WIDTH-1:0] out_clamped;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_MUL_P;
            ST_MUL_P: state_next = ST_MUL_I;
            ST_MUL_I: state_next = ST_SUM;
            ST_SUM:   state_next = ST_OUT;
            ST_OUT:   if (bus.u_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        err_rdy = (state == ST_IDLE) && !reset;
        u_vld   = (state == ST_OUT);
    end

    assign accept          = bus.error_valid && err_rdy;
    assign bus.error_ready = err_rdy;
    assign bus.u_valid     = u_vld;
    assign bus.u           = u_q;

    // The single multiplier: kp in MUL_P, ki otherwise; >>> floors toward -inf.
    assign mul_gain  = (state == ST_MUL_P) ? kp_q : ki_q;
    assign prod      = e_q * mul_gain;
    assign prod_sh   = prod >>> GAIN_FRAC;
    assign prod_wide = WIDE_WIDTH'(prod_sh);
    assign mul_res   = prod_wide[ACC_WIDTH-1:0];

    assign integ_sum = integ + mul_res;
    assign out_sum   = p_q + integ_next_q;

    sat_clamp #(
        .WIDTH_IN  (ACC_WIDTH),
        .WIDTH_LIM (DATA_WIDTH)
    ) u_integ_clamp (
        .x       (integ_sum),
        .lim_min (min_q),
        .lim_max (max_q),
        .y       (integ_clamped)
    );

    sat_clamp #(
        .WIDTH_IN  (ACC_WIDTH),
        .WIDTH_LIM (DATA_WIDTH)
    ) u_out_clamp (
        .x       (out_sum),
        .lim_min (min_q),
        .lim_max (max_q),
        .y       (out_clamped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q          <= '0;
            kp_q         <= '0;
            ki_q         <= '0;
            min_q        <= '0;
            max_q        <= '0;
            p_q          <= '0;
            integ_next_q <= '0;
            u_q          <= '0;
        end else begin
            if (accept) begin
                e_q   <= bus.error;
                kp_q  <= bus.kp;
                ki_q  <= bus.ki;
                min_q <= bus.out_min;
                max_q <= bus.out_max;
            end
            case (state)
                ST_MUL_P: p_q          <= mul_res;
                ST_MUL_I: integ_next_q <= ACC_WIDTH'(integ_clamped);
                ST_SUM:   u_q          <= out_clamped;
                default:  ;
            endcase
        end
    end

    // A clear coinciding with the SUM commit wins; u still sees integ_next_q.
    always_ff @(posedge clk) begin
        if (reset || bus.integ_clear) begin
            integ <= '0;
        end else if (state == ST_SUM) begin
            integ <= integ_next_q;
        end
    end
endmodule
